// File: rtl/clock_monitor.sv
// clock_monitor: measures a clock sampled in the clk_in domain and flags slow, fast or stuck behaviour.
// Build option: define CLK_MON_IRQ_EN to get the sticky fault interrupt (irq/irq_clr).
// Ports:
//   clk_in      reference clock, all logic on its rising edge
//   rst_n       asynchronous active-low reset
//   enable      run measurement; low aborts and idles
//   mon_clk     monitored clock, asynchronous to clk_in
//   edge_count  rising-edge count of the last completed window
//   count_valid one-cycle pulse when edge_count and flags update
//   too_slow    last window count below MIN_EDGES
//   too_fast    last window count above MAX_EDGES
//   stuck       no mon_clk transition for STUCK_LIMIT cycles
//   locked      two consecutive in-range windows with no stuck since
//   irq         sticky fault interrupt (constant 0 without CLK_MON_IRQ_EN)
//   irq_clr     clears irq (ignored without CLK_MON_IRQ_EN)
module clock_monitor #(
  parameter int WINDOW = 64,
  parameter int MIN_EDGES = 12,
  parameter int MAX_EDGES = 20,
  parameter int STUCK_LIMIT = 32,
  localparam int CW = $clog2(WINDOW + 1)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          mon_clk,
  output logic [CW-1:0] edge_count,
  output logic          count_valid,
  output logic          too_slow,
  output logic          too_fast,
  output logic          stuck,
  output logic          locked,
  output logic          irq,
  input  logic          irq_clr
);
  localparam int WW = $clog2(WINDOW);
  localparam int IW = $clog2(STUCK_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t st;
  logic s1, s2, s3;
  logic [1:0] arm_cnt, good_cnt;
  logic [WW-1:0] win_cnt;
  logic [CW-1:0] edge_acc, fin;
  logic [CW:0] sum;
  logic [IW-1:0] idle_cnt, idle_nx;
  logic rise, toggle, run, close, slow_nx, fast_nx, stuck_nx, stuck_rise;
  assign rise = s2 & ~s3;
  assign toggle = s2 ^ s3;
  assign run = st == MEAS && enable;
  assign close = run && win_cnt == WW'(WINDOW - 1);
  // the rise on the closing cycle still belongs to the finishing window
  assign sum = {1'b0, edge_acc} + {{CW{1'b0}}, rise};
  assign fin = sum[CW] ? '1 : sum[CW-1:0];
  assign slow_nx = fin < CW'(MIN_EDGES);
  assign fast_nx = fin > CW'(MAX_EDGES);
  assign idle_nx = toggle ? '0 : idle_cnt == IW'(STUCK_LIMIT) ? idle_cnt : idle_cnt + 1'b1;
  assign stuck_nx = idle_nx == IW'(STUCK_LIMIT);
  assign stuck_rise = run && stuck_nx && !stuck;
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      {s3, s2, s1} <= 3'b000;
      arm_cnt <= '0;
      good_cnt <= '0;
      win_cnt <= '0;
      edge_acc <= '0;
      idle_cnt <= '0;
      edge_count <= '0;
      count_valid <= 1'b0;
      too_slow <= 1'b0;
      too_fast <= 1'b0;
      stuck <= 1'b0;
      locked <= 1'b0;
    end else begin
      {s3, s2, s1} <= {s2, s1, mon_clk};
      count_valid <= 1'b0;
      case (st)
        IDLE: begin
          win_cnt <= '0;
          edge_acc <= '0;
          idle_cnt <= '0;
          arm_cnt <= '0;
          st <= enable ? ARM : IDLE;
        end
        ARM, MEAS: begin
          if (!enable) begin
            st <= IDLE;
            stuck <= 1'b0;
            locked <= 1'b0;
            good_cnt <= '0;
          end else if (st == ARM) begin
            // three cycles let the synchronizer history settle before counting
            arm_cnt <= arm_cnt + 1'b1;
            st <= arm_cnt == 2'd2 ? MEAS : ARM;
          end else begin
            win_cnt <= close ? '0 : win_cnt + 1'b1;
            edge_acc <= close ? '0 : fin;
            idle_cnt <= idle_nx;
            stuck <= stuck_nx;
            if (close) begin
              edge_count <= fin;
              count_valid <= 1'b1;
              too_slow <= slow_nx;
              too_fast <= fast_nx;
            end
            if (stuck_rise || (close && (slow_nx || fast_nx))) begin
              good_cnt <= '0;
              locked <= 1'b0;
            end else if (close && !stuck_nx) begin
              good_cnt <= good_cnt == 2'd2 ? good_cnt : good_cnt + 1'b1;
              locked <= good_cnt != 2'd0;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end
`ifdef CLK_MON_IRQ_EN
  logic irq_set;
  // flags are judged on their next values so irq rises together with the flag
  assign irq_set = stuck_rise || (close && ((slow_nx && !too_slow) || (fast_nx && !too_fast)));
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else irq <= irq_set ? 1'b1 : irq_clr ? 1'b0 : irq;
  end
`else
  // irq_clr has no effect in this build
  assign irq = 1'b0 & irq_clr;
`endif
endmodule

// File: tb/tb_clock_monitor.sv
// tb_clock_monitor: directed checks of clock_monitor window counting, flags, lock, abort, reset and irq.
module tb_clock_monitor;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic mon_clk = 1'b0;
  logic irq_clr = 1'b0;
  logic [6:0] edge_count;
  logic count_valid, too_slow, too_fast, stuck, locked, irq;
  int cyc = 0;
  int div = 4;
  int ph = 0;
  int last_chg = 0;
  int n_chk = 0;
  int n_pass = 0;
`ifdef CLK_MON_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  clock_monitor dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .enable(enable),
    .mon_clk(mon_clk),
    .edge_count(edge_count),
    .count_valid(count_valid),
    .too_slow(too_slow),
    .too_fast(too_fast),
    .stuck(stuck),
    .locked(locked),
    .irq(irq),
    .irq_clr(irq_clr)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;
  // mon_clk = clk_in/div, changing on falling edges; div 0 holds the level
  always @(negedge clk_in) begin
    if (div != 0) begin
      if (ph >= div / 2 - 1) begin
        ph = 0;
        mon_clk = ~mon_clk;
        last_chg = cyc;
      end else ph++;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_cv(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (count_valid) begin
        ok = 1;
        break;
      end
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    int c, s_cyc, l0, l;
    bit ok, seen;
    repeat (3) step();
    chk("rst_edge_count", edge_count, 0);
    chk("rst_count_valid", count_valid, 0);
    chk("rst_too_slow", too_slow, 0);
    chk("rst_too_fast", too_fast, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_locked", locked, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    repeat (10) step();
    chk("idle_locked", locked, 0);
    // nominal clk_in/4
    c = cyc;
    enable = 1'b1;
    wait_cv("nom_cv1");
    chk("nom_latency", cyc, c + 68);
    chk("nom_count1", edge_count, 16);
    chk("nom_slow", too_slow, 0);
    chk("nom_fast", too_fast, 0);
    chk("nom_locked1", locked, 0);
    step();
    chk("nom_pulse", count_valid, 0);
    wait_cv("nom_cv2");
    chk("nom_period", cyc, c + 132);
    chk("nom_count2", edge_count, 16);
    chk("nom_locked2", locked, 1);
    // fast clk_in/2, then slow clk_in/8
    div = 2;
    wait_cv("fast_cv_t");
    wait_cv("fast_cv");
    chk("fast_count", edge_count, 32);
    chk("fast_flag", too_fast, 1);
    chk("fast_slow", too_slow, 0);
    chk("fast_locked", locked, 0);
    chk("fast_irq", irq, IRQ_ON);
    irq_clr = 1'b1;
    div = 8;
    step();
    irq_clr = 1'b0;
    chk("irq_cleared", irq, 0);
    wait_cv("slow_cv_t");
    wait_cv("slow_cv");
    chk("slow_count", edge_count, 8);
    chk("slow_flag", too_slow, 1);
    chk("slow_fast", too_fast, 0);
    chk("slow_irq", irq, IRQ_ON);
    // relock at clk_in/4
    div = 4;
    wait_cv("relock_cv1");
    wait_cv("relock_cv2");
    wait_cv("relock_cv3");
    chk("relock_count", edge_count, 16);
    chk("relock_locked", locked, 1);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("irq_cleared2", irq, 0);
    // stuck: hold mon_clk high, irq_clr coincident with stuck rising
    for (int i = 0; i < 4 && !mon_clk; i++) step();
    div = 0;
    s_cyc = last_chg + 35;
    for (int i = 0; i < 100 && cyc < s_cyc - 1; i++) step();
    chk("stuck_pre", stuck, 0);
    chk("stuck_pre_locked", locked, 1);
    chk("stuck_pre_irq", irq, 0);
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    chk("stuck_cycle", cyc, s_cyc);
    chk("stuck_set", stuck, 1);
    chk("stuck_unlock", locked, 0);
    chk("stuck_irq", irq, IRQ_ON);
    l0 = last_chg;
    div = 4;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_chg != l0) begin
        ok = 1;
        break;
      end
    end
    chk("resume_toggle", ok, 1);
    l = last_chg;
    for (int i = 0; i < 10 && stuck; i++) step();
    chk("stuck_clr_cycle", cyc, l + 3);
    chk("stuck_clr", stuck, 0);
    wait_cv("stuck_cv1");
    chk("stuck_win_slow", too_slow, 1);
    chk("stuck_win_locked", locked, 0);
    wait_cv("stuck_cv2");
    chk("stuck_cv2_count", edge_count, 16);
    chk("stuck_cv2_locked", locked, 0);
    wait_cv("stuck_cv3");
    chk("stuck_cv3_count", edge_count, 16);
    chk("stuck_cv3_locked", locked, 1);
    // abort at win_cnt=30
    repeat (30) step();
    enable = 1'b0;
    step();
    chk("abort_locked", locked, 0);
    chk("abort_stuck", stuck, 0);
    chk("abort_count_hold", edge_count, 16);
    chk("abort_slow_hold", too_slow, 0);
    chk("abort_fast_hold", too_fast, 0);
    seen = 0;
    repeat (80) begin
      step();
      if (count_valid) seen = 1;
    end
    chk("abort_no_cv", seen, 0);
    c = cyc;
    enable = 1'b1;
    wait_cv("reen_cv1");
    chk("reen_latency", cyc, c + 68);
    chk("reen_count", edge_count, 16);
    chk("reen_locked1", locked, 0);
    wait_cv("reen_cv2");
    chk("reen_locked2", locked, 1);
    // asynchronous reset mid-window
    repeat (10) step();
    chk("prereset_locked", locked, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_edge_count", edge_count, 0);
    chk("arst_locked", locked, 0);
    chk("arst_slow", too_slow, 0);
    chk("arst_fast", too_fast, 0);
    chk("arst_stuck", stuck, 0);
    chk("arst_cv", count_valid, 0);
    chk("arst_irq", irq, 0);
    enable = 1'b0;
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (80) begin
      step();
      if (count_valid) seen = 1;
    end
    chk("post_rst_idle", seen, 0);
    c = cyc;
    enable = 1'b1;
    wait_cv("post_rst_cv");
    chk("post_rst_latency", cyc, c + 68);
    chk("post_rst_count", edge_count, 16);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
